// File: rtl/ccff_ctrl_pkg.sv
// Shared definitions for the configuration-chain load controller.
//   ccff_state_t   : controller state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//   WORD_W_DEF     : default bitstream word width
//   CHAIN_LEN_DEF  : default configuration chain length in bits
//   idx_width()    : width of an index over n items (at least 1 bit)
package ccff_ctrl_pkg;

    localparam int unsigned WORD_W_DEF    = 8;
    localparam int unsigned CHAIN_LEN_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_state_t;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it LSB-first, one bit per shift.
//   CK, RN  : clock, async active-low reset
//   load    : capture data into the shift register, restart the bit index
//   shift   : advance one bit (zero fill from the top)
//   clear   : drop any remaining bits; wins over load and shift
//   data    : word to capture
//   head    : current bit, taken straight from the register
//   last_c  : the bit on head is the last bit of the word
module ccff_word_serializer
    import ccff_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [WORD_W-1:0] data,
    output logic              head,
    output logic              last_c
);

    localparam int unsigned IDX_W = idx_width(WORD_W);

    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  widx;

    // Zero fill keeps head low once a full word has gone out; clear covers
    // the truncated last word and aborts so head is low whenever not shifting.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sreg <= '0;
            widx <= '0;
        end else if (clear) begin
            sreg <= '0;
            widx <= '0;
        end else if (load) begin
            sreg <= data;
            widx <= '0;
        end else if (shift) begin
            sreg <= sreg >> 1;
            widx <= widx + IDX_W'(1);
        end
    end

    assign head   = sreg[0];
    assign last_c = (widx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_load_ctrl.sv
// Loads the fabric configuration chain from a valid/ready word stream,
// serializing each word LSB-first and stopping after exactly CHAIN_LEN bits.
//   CK, RN        : clock (shared with chain cells), async active-low reset
//   start         : begin a load (honoured only in IDLE/DONE)
//   abort         : cancel; highest priority in every state
//   in_valid      : bitstream word valid
//   in_data       : bitstream word, bit 0 shifted first
//   in_ready      : word accepted when in_valid & in_ready (LOAD only)
//   ccff_head     : serial data to chain head (0 when not shifting)
//   ccff_shift_en : chain clock enable
//   busy          : load in progress (LOAD or SHIFT)
//   done          : load complete (level, held in DONE)
//   err           : sticky, set when a busy load is aborted
//   parity        : XOR of all bits shifted in the current load
module ccff_load_ctrl
    import ccff_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              parity
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    ccff_state_t      state;
    logic [CNT_W-1:0] bit_cnt;

    logic accept_c;
    logic shift_c;
    logic last_bit_c;
    logic word_last_c;
    logic ser_clear_c;

    // Handshake and shift qualified by abort so an aborted cycle moves nothing.
    assign accept_c    = (state == LOAD) & in_valid & ~abort;
    assign shift_c     = (state == SHIFT) & ~abort;
    assign last_bit_c  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign ser_clear_c = abort | (shift_c & last_bit_c);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .CK     (CK),
        .RN     (RN),
        .load   (accept_c),
        .shift  (shift_c),
        .clear  (ser_clear_c),
        .data   (in_data),
        .head   (ccff_head),
        .last_c (word_last_c)
    );

    // Controller FSM; every output flop is written with the value that
    // matches the state being entered.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            parity        <= 1'b0;
            err           <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            in_ready      <= 1'b0;
            ccff_shift_en <= 1'b0;
        end else if (abort) begin
            if ((state == LOAD) || (state == SHIFT)) begin
                err <= 1'b1;
            end
            state         <= IDLE;
            done          <= 1'b0;
            busy          <= 1'b0;
            in_ready      <= 1'b0;
            ccff_shift_en <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        bit_cnt  <= '0;
                        parity   <= 1'b0;
                        err      <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state         <= SHIFT;
                        in_ready      <= 1'b0;
                        ccff_shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    parity  <= parity ^ ccff_head;
                    // Chain full wins over word boundary: leftover bits are dropped.
                    if (last_bit_c) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        ccff_shift_en <= 1'b0;
                    end else if (word_last_c) begin
                        state         <= LOAD;
                        in_ready      <= 1'b1;
                        ccff_shift_en <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Self-checking bench for ccff_load_ctrl (WORD_W=8, CHAIN_LEN=20).
// Expected chain contents come from the word list: words concatenated
// LSB-first and truncated to CHAIN_LEN bits; parity is their XOR.
module tb_ccff_load_ctrl;

    localparam int unsigned WW = 8;
    localparam int unsigned CL = 20;

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          busy;
    logic          done;
    logic          err;
    logic          parity;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [WW-1:0] words [8];
    int            n_words;
    logic          cap [$];
    logic [CL-1:0] got_bits;

    always #5 CK = ~CK;

    ccff_load_ctrl #(
        .WORD_W    (WW),
        .CHAIN_LEN (CL)
    ) dut (
        .CK            (CK),
        .RN            (RN),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .parity        (parity)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_head"}, ccff_head, 0);
        chk({pfx, "_shift_en"}, ccff_shift_en, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_parity"}, parity, 0);
    endtask

    // Chain view: record head on every enabled cycle; head must idle low.
    always @(negedge CK) begin
        if (RN) begin
            if (ccff_shift_en) cap.push_back(ccff_head);
            else chk("head_idle", ccff_head, 0);
        end
    end

    // Reference: what the chain should hold after a full load of words[0:n_words-1].
    task automatic model(output logic [CL-1:0] bits, output logic par, output int used);
        int k;
        k = 0;
        par = 1'b0;
        bits = '0;
        used = 0;
        for (int w = 0; w < n_words && k < CL; w++) begin
            used++;
            for (int b = 0; b < WW && k < CL; b++) begin
                bits[k] = words[w][b];
                par ^= words[w][b];
                k++;
            end
        end
    endtask

    // One complete load: gap = idle cycles with in_ready high before each word,
    // mid_start >= 0 pulses start while shifting after that many bits.
    task automatic run_load(input int gap, input int mid_start);
        int            gc;
        int            budget;
        int            accepted;
        logic          hs;
        logic [CL-1:0] exp_bits;
        logic          exp_par;
        logic          par_hold;
        int            exp_used;
        gc = 0;
        budget = 0;
        accepted = 0;
        cap.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_err_clr", err, 0);
        chk("load_done_clr", done, 0);
        chk("load_ready", in_ready, 1);
        while (!done && budget < 1000) begin
            in_valid = in_ready && (accepted < n_words) && (gc >= gap);
            if (in_valid) in_data = words[accepted];
            if (in_ready) chk("load_frozen", ccff_shift_en, 0);
            start = (mid_start >= 0) && ccff_shift_en && (cap.size() == mid_start);
            hs = in_valid & in_ready;
            tick();
            budget++;
            if (hs) begin
                accepted++;
                gc = 0;
            end else if (in_ready) begin
                gc++;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        model(exp_bits, exp_par, exp_used);
        got_bits = '0;
        for (int i = 0; i < CL && i < cap.size(); i++) got_bits[i] = cap[i];
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_shift_en", ccff_shift_en, 0);
        chk("done_ready", in_ready, 0);
        chk("shift_cycles", cap.size(), CL);
        chk("words_used", accepted, exp_used);
        chk("parity", parity, exp_par);
        chk("head_seq", got_bits, exp_bits);
        // Offered words in DONE must be ignored and results held.
        par_hold = parity;
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        chk("done_hold", done, 1);
        chk("done_no_ready", in_ready, 0);
        chk("done_par_hold", parity, par_hold);
        chk("done_no_shift", cap.size(), CL);
    endtask

    initial begin : main
        int   acc;
        int   budget;
        logic hs;

        // Reset state.
        #12;
        chk_all_zero("rst");
        @(negedge CK);
        RN = 1'b1;
        tick();
        chk_all_zero("post_rst");

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF7;
        n_words = 3;

        // Back-to-back words.
        run_load(0, -1);
        chk("spec_seq", got_bits, 20'h73CA5);
        chk("spec_par", parity, 1);

        // Same words with in_valid gaps; start here also exercises start-in-DONE.
        run_load(5, -1);
        chk("gap_seq", got_bits, 20'h73CA5);
        chk("gap_par", parity, 1);

        // start pulsed mid-shift must not disturb the load.
        run_load(0, 5);
        chk("midstart_seq", got_bits, 20'h73CA5);

        // Abort after 10 shifted bits.
        cap.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        budget = 0;
        while (cap.size() < 10 && budget < 200) begin
            in_valid = in_ready && (acc < n_words);
            if (in_valid) in_data = words[acc];
            hs = in_valid & in_ready;
            tick();
            budget++;
            if (hs) acc++;
        end
        in_valid = 1'b0;
        chk("abort_reach", cap.size(), 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 1);
        chk("abort_shift_en", ccff_shift_en, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_done", done, 0);
        tick();
        tick();
        chk("abort_err_sticky", err, 1);
        chk("abort_idle", busy, 0);
        // Restart clears err and loads from bit 0.
        run_load(0, -1);
        chk("restart_seq", got_bits, 20'h73CA5);

        // abort and in_valid in the same LOAD cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_load_ready", in_ready, 1);
        cap.delete();
        in_valid = 1'b1;
        in_data = 8'hFF;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_ready", in_ready, 0);
        chk("ab_err", err, 1);
        chk("ab_busy", busy, 0);
        chk("ab_shift_en", ccff_shift_en, 0);
        tick();
        tick();
        in_valid = 1'b0;
        chk("ab_no_accept", cap.size(), 0);
        chk("ab_ready_after", in_ready, 0);
        // Abort while idle leaves err alone.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_err", err, 1);
        chk("idle_abort_done", done, 0);

        // Abort in DONE clears done, err stays clear.
        run_load(1, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("done_abort_done", done, 0);
        chk("done_abort_err", err, 0);

        // Randomized loads with random word counts, gaps and stray starts.
        for (int r = 0; r < 8; r++) begin
            n_words = 3 + int'($urandom_range(0, 2));
            for (int w = 0; w < 8; w++) words[w] = WW'($urandom);
            run_load(int'($urandom_range(0, 3)), (r % 2 == 1) ? int'($urandom_range(0, 18)) : -1);
        end

        // Reset mid-SHIFT: outputs drop without waiting for an edge.
        n_words = 3;
        words[0] = 8'hFF;
        words[1] = 8'hFF;
        words[2] = 8'hFF;
        cap.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = words[0];
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_shift", ccff_shift_en, 1);
        #3;
        RN = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge CK);
        RN = 1'b1;
        tick();
        chk_all_zero("mid_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
